// File: rtl/dm_cache_pkg.sv
// Shared types and address-field constants for the direct-mapped cache controller.
package dm_cache_pkg;

    localparam int TAG_W     = 18;
    localparam int INDEX_W   = 8;
    localparam int OFFSET_W  = 6;
    localparam int BEATS     = 16;
    localparam int WORD_W    = $clog2(BEATS);

    // Bit positions of the fields inside a byte address
    localparam int INDEX_LSB = OFFSET_W;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        REFILL,
        RESP
    } state_e;

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Request/response and refill-memory bus of dm_cache_ctrl; slave = controller side.
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rdata_valid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
        output req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
        input  req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/dm_cache_tag_ram.sv
// Tag array (unreset storage) plus per-line valid bits cleared asynchronously by rst_n.
module dm_cache_tag_ram #(
    parameter int INDEX_W = dm_cache_pkg::INDEX_W,
    parameter int TAG_W   = dm_cache_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid
);
    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0] tag_array [LINES];
    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (we) tag_array[wr_index] <= wr_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  valid_q           <= '0;
        else if (we) valid_q[wr_index] <= wr_valid;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_array[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache lookup/refill controller with optional hit/miss statistics.
// Statistics counters are built only when DM_CACHE_CTRL_STATS_EN is defined.
module dm_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = dm_cache_pkg::INDEX_W,
    parameter int OFFSET_W = dm_cache_pkg::OFFSET_W,
    parameter int BEATS    = dm_cache_pkg::BEATS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dm_cache_ctrl_if.slave           bus,
    output logic                     arr_we,
    output logic [INDEX_W-1:0]       arr_index,
    output logic [$clog2(BEATS)-1:0] arr_word,
    output logic [31:0]              arr_wdata,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    import dm_cache_pkg::*;

    localparam int TAG_BITS  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_BITS = $clog2(BEATS);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:OFFSET_W]  line_q;
    logic [WORD_BITS-1:0]      beat_q;
    logic                      hit_q;
    logic [INDEX_W-1:0]        idx;
    logic [TAG_BITS-1:0]       tag;
    logic                      rd_valid;
    logic [TAG_BITS-1:0]       rd_tag;
    logic                      lookup_hit;
    logic                      last_beat;
    logic                      tr_we;
    logic                      tr_wvalid;
    logic                      unused_offset;

    // The byte offset never matters to a whole-line controller
    assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

    assign idx        = line_q[OFFSET_W +: INDEX_W];
    assign tag        = line_q[ADDR_W-1 -: TAG_BITS];
    assign lookup_hit = rd_valid && (rd_tag == tag);
    assign last_beat  = (beat_q == WORD_BITS'(BEATS - 1));

    // A miss invalidates the line up front so a half-written refill is never hit
    assign tr_we     = ((state_q == LOOKUP) && !lookup_hit) ||
                       ((state_q == REFILL) && bus.mem_rdata_valid && last_beat);
    assign tr_wvalid = (state_q == REFILL);

    dm_cache_tag_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_BITS)
    ) u_tag_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .we       (tr_we),
        .wr_index (idx),
        .wr_tag   (tag),
        .wr_valid (tr_wvalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MEM_REQ) beat_q <= '0;
            else if (arr_we)        beat_q <= beat_q + 1'b1;
            if (state_q == LOOKUP)  hit_q  <= lookup_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) line_q <= bus.req_addr[ADDR_W-1:OFFSET_W];
    end

    always_comb begin
        state_d           = state_q;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.mem_req_valid = 1'b0;
        arr_we            = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted even though the state is IDLE
                bus.req_ready = rst_n;
                if (bus.req_valid && rst_n) state_d = LOOKUP;
            end
            LOOKUP:  state_d = lookup_hit ? RESP : MEM_REQ;
            MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = REFILL;
            end
            REFILL: begin
                arr_we = bus.mem_rdata_valid;
                if (bus.mem_rdata_valid && last_beat) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.resp_hit     = hit_q;
    assign bus.mem_req_addr = {line_q, {OFFSET_W{1'b0}}};
    assign arr_index        = idx;
    assign arr_word         = beat_q;
    assign arr_wdata        = bus.mem_rdata;

`ifdef DM_CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (lookup_hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else            miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; INDEX_W, default 8, line index width (256 lines); OFFSET_W, default 6, byte offset width (64-byte line); BEATS, default 16, 32-bit refill beats per line.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester has a lookup address.
REQ-005 req_addr  input  32  byte address; tag = [31:14], index = [13:6], offset = [5:0].
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 resp_valid  output  1  one-cycle completion pulse.
REQ-008 resp_hit  output  1  qualifies resp_valid: 1 = hit, 0 = miss serviced by refill.
REQ-009 mem_req_valid / mem_req_ready  output / input  1 / 1  refill request handshake.
REQ-010 mem_req_addr  output  32  line-aligned refill address, bits [5:0] = 0.
REQ-011 mem_rdata_valid / mem_rdata  input / input  1 / 32  refill beat.
REQ-012 arr_we, arr_index, arr_word, arr_wdata  output  1, 8, 4, 32  data-array write port.
REQ-013 hit_count, miss_count  output  32, 32  statistics counters.

Function
REQ-014 FSM states SHALL be IDLE, LOOKUP, MEM_REQ, REFILL, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; req_valid && req_ready latches req_addr and moves to LOOKUP.
REQ-016 LOOKUP: hit = valid[index] && tag_array[index] == tag; hit -> RESP with resp_hit = 1; miss -> MEM_REQ.
REQ-017 Hit latency SHALL be exactly 2 cycles from acceptance edge to resp_valid.
REQ-018 MEM_REQ: mem_req_valid = 1 and mem_req_addr held stable until mem_req_ready; handshake -> REFILL with beat counter = 0.
REQ-019 REFILL: each mem_rdata_valid beat drives arr_we = 1 combinationally, arr_index = latched index, arr_word = beat counter, arr_wdata = mem_rdata; counter increments.
REQ-020 Beats arriving outside REFILL SHALL be ignored (arr_we = 0).
REQ-021 Gaps between beats SHALL be tolerated with no timeout.
REQ-022 On the BEATS-th beat: tag_array[index] <= tag, valid[index] <= 1, next state RESP with resp_hit = 0.
REQ-023 RESP: resp_valid = 1 for exactly one cycle, then IDLE; no back-to-back acceptance in RESP.
REQ-024 hit_count increments in LOOKUP on hit; miss_count increments in LOOKUP on miss.
REQ-025 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-026 A repeated miss to an index SHALL overwrite that line (direct-mapped, no victim buffer).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE; clear all valid bits, beat counter, hit_count and miss_count.
REQ-028 During reset: req_ready = 0, resp_valid = 0, mem_req_valid = 0, arr_we = 0; req_ready = 1 on the first cycle after release.
REQ-029 Reset mid-refill SHALL abandon the line; the index stays invalid and later beats are ignored.
REQ-030 tag_array SHALL NOT be reset.

Configuration
REQ-031 DM_CACHE_CTRL_STATS_EN defined: counters implemented as above.
REQ-032 DM_CACHE_CTRL_STATS_EN undefined: hit_count and miss_count tied to 0, no counter flops; all other behaviour identical.

Structure
REQ-033 Shared package dm_cache_pkg SHALL hold: state enum, TAG_W = 18, INDEX_W, OFFSET_W, BEATS, and the address field-extraction constants.
REQ-034 Sub-module dm_cache_tag_ram SHALL hold tag_array and valid bits (1 read, 1 write port, async valid clear).

Verification
REQ-035 Cold miss: after reset, req 0x0000_1040 -> mem_req_addr 0x0000_1040; 16 beats -> arr_word 0..15 at arr_index 0x41; resp_hit = 0; miss_count = 1.
REQ-036 Hit: repeat 0x0000_107C -> resp_valid 2 cycles after acceptance, resp_hit = 1, no mem_req_valid; hit_count = 1.
REQ-037 Conflict: 0x0000_1040, then 0x0000_5040 (same index 0x41, new tag), then 0x0000_1040 -> miss, miss, miss; miss_count = 3.
REQ-038 Backpressure: mem_req_ready low 5 cycles and beat gaps of 3 cycles -> address stable, exactly 16 arr_we pulses, one resp_valid.
REQ-039 Reset at beat 8 of refill for 0x0000_2000 -> IDLE; stray beats give no arr_we; next req 0x0000_2000 misses.
REQ-040 Saturation: preload hit_count = 0xFFFFFFFE (force), two hits -> hit_count = 0xFFFFFFFF; with macro undefined, both counters read 0.
